// File: rtl/gemm_acc_rmw.sv
// gemm_acc_rmw: read-modify-write sequencer around the combinational gemm_op core.
// Reads inp/wgt/acc rows, captures gemm_op result, writes it back to the acc row.
module gemm_acc_rmw #(
    parameter int INP_ADDR_W = 4,
    parameter int WGT_ADDR_W = 4,
    parameter int ACC_ADDR_W = 6,
    parameter int ACC_WIDTH  = 32,
    parameter int INP_DEPTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // command interface
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [INP_ADDR_W-1:0]             cmd_inp_addr,
    input  logic [WGT_ADDR_W-1:0]             cmd_wgt_addr,
    input  logic [ACC_ADDR_W-1:0]             cmd_acc_addr,
    input  logic                              cmd_zero,
    // input / weight BRAM read ports
    output logic                              inp_en,
    output logic [INP_ADDR_W-1:0]             inp_addr,
    output logic                              wgt_en,
    output logic [WGT_ADDR_W-1:0]             wgt_addr,
    // accumulator BRAM port
    output logic                              acc_en,
    output logic                              acc_we,
    output logic [ACC_ADDR_W-1:0]             acc_addr,
    output logic [ACC_WIDTH*INP_DEPTH-1:0]    acc_din,
    input  logic [ACC_WIDTH*INP_DEPTH-1:0]    acc_dout,
    // gemm_op connection
    output logic [ACC_WIDTH*INP_DEPTH-1:0]    a_tensor,
    input  logic [ACC_WIDTH*INP_DEPTH-1:0]    o_tensor,
    // status
    output logic                              done,
    output logic                              busy
);

    localparam int AT_WIDTH = ACC_WIDTH * INP_DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_hs;

    logic [INP_ADDR_W-1:0]  r_inp_addr;
    logic [WGT_ADDR_W-1:0]  r_wgt_addr;
    logic [ACC_ADDR_W-1:0]  r_acc_addr;
    logic                   r_zero;
    logic [AT_WIDTH-1:0]    r_wb;

    assign w_hs = cmd_valid && cmd_ready;

    // Addresses always come from the latched command; enables gate their use.
    assign inp_addr = r_inp_addr;
    assign wgt_addr = r_wgt_addr;
    assign acc_addr = r_acc_addr;
    assign acc_din  = r_wb;

    // Overwrite mode substitutes zero for the stored accumulator row.
    assign a_tensor = r_zero ? '0 : acc_dout;

    // State register; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs, decoded from the current state.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        inp_en    = 1'b0;
        wgt_en    = 1'b0;
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = RD;
                end
            end
            RD: begin
                inp_en = 1'b1;
                wgt_en = 1'b1;
                acc_en = 1'b1;
                w_next = CAP;
            end
            CAP: begin
                w_next = WR;
            end
            WR: begin
                acc_en    = 1'b1;
                acc_we    = 1'b1;
                done      = 1'b1;
                cmd_ready = 1'b1;
                w_next    = cmd_valid ? RD : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command fields are captured only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inp_addr <= '0;
            r_wgt_addr <= '0;
            r_acc_addr <= '0;
            r_zero     <= 1'b0;
        end else if (w_hs) begin
            r_inp_addr <= cmd_inp_addr;
            r_wgt_addr <= cmd_wgt_addr;
            r_acc_addr <= cmd_acc_addr;
            r_zero     <= cmd_zero;
        end
    end

    // Capture the gemm_op result while the BRAM read data is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb <= '0;
        end else if (r_state == CAP) begin
            r_wb <= o_tensor;
        end
    end

endmodule

// File: tb/tb_gemm_acc_rmw.sv
// tb_gemm_acc_rmw: bench for gemm_acc_rmw with behavioural BRAMs and gemm_op.
// Expected write-backs are queued at each handshake and checked at acc_we.
module tb_gemm_acc_rmw;

    localparam int AT = 512;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_inp_addr;
    logic [3:0]      cmd_wgt_addr;
    logic [5:0]      cmd_acc_addr;
    logic            cmd_zero;
    logic            inp_en;
    logic [3:0]      inp_addr;
    logic            wgt_en;
    logic [3:0]      wgt_addr;
    logic            acc_en;
    logic            acc_we;
    logic [5:0]      acc_addr;
    logic [AT-1:0]   acc_din;
    logic [AT-1:0]   acc_dout;
    logic [AT-1:0]   a_tensor;
    logic [AT-1:0]   o_tensor;
    logic            done;
    logic            busy;

    gemm_acc_rmw dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_inp_addr (cmd_inp_addr),
        .cmd_wgt_addr (cmd_wgt_addr),
        .cmd_acc_addr (cmd_acc_addr),
        .cmd_zero     (cmd_zero),
        .inp_en       (inp_en),
        .inp_addr     (inp_addr),
        .wgt_en       (wgt_en),
        .wgt_addr     (wgt_addr),
        .acc_en       (acc_en),
        .acc_we       (acc_we),
        .acc_addr     (acc_addr),
        .acc_din      (acc_din),
        .acc_dout     (acc_dout),
        .a_tensor     (a_tensor),
        .o_tensor     (o_tensor),
        .done         (done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memories: inp row = 16 x 8b, wgt block = 16x16 x 8b, acc row = 16 x 32b
    logic [127:0]    inp_mem [16];
    logic [2047:0]   wgt_mem [16];
    logic [AT-1:0]   acc_mem [64];
    logic [127:0]    inp_q;
    logic [2047:0]   wgt_q;
    logic [AT-1:0]   acc_q;
    logic [31:0]     shadow [64][16];

    logic            pre_we;
    logic [5:0]      pre_addr;
    logic [AT-1:0]   pre_data;

    typedef struct {
        logic [5:0]    addr;
        logic [AT-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks;
    int errors;
    int cyc;
    int wr_cnt;
    int wr_cyc_last;
    int wr_cyc_prev;
    int hs_cyc;
    logic hs_done;

    function automatic logic [31:0] lane_sum(input logic [127:0] irow,
                                             input logic [2047:0] wblk,
                                             input int j);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 16; k++) begin
            s = s + 32'(irow[k*8 +: 8]) * 32'(wblk[(j*16+k)*8 +: 8]);
        end
        return s;
    endfunction

    function automatic logic [AT-1:0] gemm_f(input logic [AT-1:0] a,
                                             input logic [127:0] irow,
                                             input logic [2047:0] wblk);
        logic [AT-1:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[j*32 +: 32] = a[j*32 +: 32] + lane_sum(irow, wblk, j);
        end
        return r;
    endfunction

    // combinational gemm_op model
    assign o_tensor = gemm_f(a_tensor, inp_q, wgt_q);
    assign acc_dout = acc_q;

    // single-port BRAMs, 1-cycle read latency, read-first on write
    always @(posedge clk) begin
        if (inp_en) inp_q <= inp_mem[inp_addr];
        if (wgt_en) wgt_q <= wgt_mem[wgt_addr];
        if (acc_en) begin
            acc_q <= acc_mem[acc_addr];
            if (acc_we) acc_mem[acc_addr] <= acc_din;
        end else if (pre_we) begin
            acc_mem[pre_addr] <= pre_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // write-back monitor / scoreboard
    always @(negedge clk) begin
        if (acc_we === 1'b1) begin
            exp_t e;
            wr_cnt      = wr_cnt + 1;
            wr_cyc_prev = wr_cyc_last;
            wr_cyc_last = cyc;
            checks      = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL wb_unexpected: addr=%0d got write, expected none",
                         acc_addr);
            end else begin
                e = exp_q.pop_front();
                if (acc_addr !== e.addr || acc_din !== e.data || done !== 1'b1) begin
                    errors = errors + 1;
                    $display("FAIL wb: addr=%0d done=%b data=%h expected addr=%0d data=%h",
                             acc_addr, done, acc_din, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_inp(input int a, input logic [7:0] v);
        inp_mem[a] = {16{v}};
    endtask

    task automatic set_wgt(input int a, input logic [7:0] v);
        wgt_mem[a] = {256{v}};
    endtask

    task automatic preload_acc(input logic [5:0] a, input logic [31:0] v);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = {16{v}};
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        for (int j = 0; j < 16; j++) shadow[a][j] = v;
    endtask

    // Drives a command, waits (bounded) for the handshake, queues the result.
    task automatic drive_cmd(input logic [3:0] ia, input logic [3:0] wa,
                             input logic [5:0] aa, input logic z);
        int n;
        exp_t e;
        n = 0;
        cmd_valid    = 1'b1;
        cmd_inp_addr = ia;
        cmd_wgt_addr = wa;
        cmd_acc_addr = aa;
        cmd_zero     = z;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: cmd_ready=%b expected 1", cmd_ready);
        end
        hs_done = done;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        e.addr = aa;
        e.data = '0;
        for (int j = 0; j < 16; j++) begin
            logic [31:0] v;
            v = (z ? 32'd0 : shadow[aa][j]) + lane_sum(inp_mem[ia], wgt_mem[wa], j);
            shadow[aa][j] = v;
            e.data[j*32 +: 32] = v;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        logic [6:0] st;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b0010000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", st, 7'b0010000);
        end
        checks++;
        if ({inp_addr, wgt_addr, acc_addr} !== 14'd0 || acc_din !== '0) begin
            errors++;
            $display("FAIL reset_regs: addrs=%h din_nonzero=%b expected 0",
                     {inp_addr, wgt_addr, acc_addr}, |acc_din);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [6:0] st;
        preload_acc(6'd3, 32'd10);
        drive_cmd(4'd1, 4'd2, 6'd3, 1'b0);
        cmd_valid = 1'b0;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b1001110) begin
            errors++;
            $display("FAIL single_rd: got %b expected %b", st, 7'b1001110);
        end
        checks++;
        if (inp_addr !== 4'd1 || wgt_addr !== 4'd2 || acc_addr !== 6'd3) begin
            errors++;
            $display("FAIL single_rd_addr: got %0d/%0d/%0d expected 1/2/3",
                     inp_addr, wgt_addr, acc_addr);
        end
        @(posedge clk);
        #1;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b1000000) begin
            errors++;
            $display("FAIL single_cap: got %b expected %b", st, 7'b1000000);
        end
        @(posedge clk);
        #1;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b1110011) begin
            errors++;
            $display("FAIL single_wr: got %b expected %b", st, 7'b1110011);
        end
        @(posedge clk);
        #1;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b0010000) begin
            errors++;
            $display("FAIL single_idle: got %b expected %b", st, 7'b0010000);
        end
        checks++;
        if (acc_mem[3] !== {16{32'd26}}) begin
            errors++;
            $display("FAIL single_mem: lane0=%0d expected 26", acc_mem[3][31:0]);
        end
    endtask

    task automatic test_overwrite();
        preload_acc(6'd3, 32'h1234_5678);
        drive_cmd(4'd1, 4'd2, 6'd3, 1'b1);
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (acc_mem[3] !== {16{32'd16}}) begin
            errors++;
            $display("FAIL overwrite_mem: lane0=%0d expected 16", acc_mem[3][31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int first_hs;
        preload_acc(6'd5, 32'd0);
        drive_cmd(4'd1, 4'd2, 6'd5, 1'b0);
        first_hs = hs_cyc;
        drive_cmd(4'd1, 4'd2, 6'd5, 1'b0);
        cmd_valid = 1'b0;
        checks++;
        if (hs_done !== 1'b1 || hs_cyc - first_hs != 3) begin
            errors++;
            $display("FAIL b2b_handshake: done=%b gap=%0d expected done=1 gap=3",
                     hs_done, hs_cyc - first_hs);
        end
        wait_idle();
        checks++;
        if (wr_cyc_last - wr_cyc_prev != 3) begin
            errors++;
            $display("FAIL b2b_done_gap: got %0d expected 3", wr_cyc_last - wr_cyc_prev);
        end
        checks++;
        if (acc_mem[5] !== {16{32'd32}}) begin
            errors++;
            $display("FAIL b2b_mem: lane0=%0d expected 32", acc_mem[5][31:0]);
        end
    endtask

    task automatic test_backpressure();
        int base;
        set_inp(4, 8'd2);
        set_wgt(5, 8'd3);
        set_inp(6, 8'd1);
        set_wgt(7, 8'd2);
        preload_acc(6'd7, 32'd100);
        preload_acc(6'd8, 32'd5);
        preload_acc(6'd20, 32'h77);
        preload_acc(6'd21, 32'h88);
        base = wr_cnt;
        drive_cmd(4'd4, 4'd5, 6'd7, 1'b0);
        cmd_inp_addr = 4'd9;
        cmd_wgt_addr = 4'd9;
        cmd_acc_addr = 6'd20;
        cmd_zero     = 1'b1;
        @(posedge clk);
        #1;
        cmd_inp_addr = 4'd10;
        cmd_wgt_addr = 4'd10;
        cmd_acc_addr = 6'd21;
        cmd_zero     = 1'b0;
        @(posedge clk);
        #1;
        drive_cmd(4'd6, 4'd7, 6'd8, 1'b0);
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (wr_cnt - base != 2) begin
            errors++;
            $display("FAIL bp_write_count: got %0d expected 2", wr_cnt - base);
        end
        checks++;
        if (acc_mem[7] !== {16{32'd196}} || acc_mem[8] !== {16{32'd37}}) begin
            errors++;
            $display("FAIL bp_mem: acc7=%0d acc8=%0d expected 196/37",
                     acc_mem[7][31:0], acc_mem[8][31:0]);
        end
        checks++;
        if (acc_mem[20] !== {16{32'h77}} || acc_mem[21] !== {16{32'h88}}) begin
            errors++;
            $display("FAIL bp_untouched: acc20=%h acc21=%h expected 77/88",
                     acc_mem[20][31:0], acc_mem[21][31:0]);
        end
    endtask

    task automatic test_wrap();
        preload_acc(6'd9, 32'hFFFF_FFF0);
        drive_cmd(4'd1, 4'd2, 6'd9, 1'b0);
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (acc_mem[9] !== '0) begin
            errors++;
            $display("FAIL wrap_mem: lane0=%h expected 00000000", acc_mem[9][31:0]);
        end
    endtask

    task automatic test_reset_cap();
        logic [AT-1:0] snap;
        logic [31:0]   sh [16];
        logic [6:0]    st;
        int            base;
        snap = acc_mem[3];
        for (int j = 0; j < 16; j++) sh[j] = shadow[3][j];
        base = wr_cnt;
        drive_cmd(4'd4, 4'd5, 6'd3, 1'b1);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        st = {busy, done, cmd_ready, inp_en, wgt_en, acc_en, acc_we};
        checks++;
        if (st !== 7'b0010000) begin
            errors++;
            $display("FAIL rst_cap_ctrl: got %b expected %b", st, 7'b0010000);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        for (int j = 0; j < 16; j++) shadow[3][j] = sh[j];
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != base || acc_mem[3] !== snap) begin
            errors++;
            $display("FAIL rst_cap_nowrite: writes=%0d lane0=%0d expected 0 writes lane0=%0d",
                     wr_cnt - base, acc_mem[3][31:0], snap[31:0]);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_cap_ready: ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
        drive_cmd(4'd1, 4'd2, 6'd3, 1'b0);
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (acc_mem[3] !== {16{32'd32}}) begin
            errors++;
            $display("FAIL rst_cap_resume: lane0=%0d expected 32", acc_mem[3][31:0]);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        wr_cnt       = 0;
        wr_cyc_last  = 0;
        wr_cyc_prev  = 0;
        hs_cyc       = 0;
        hs_done      = 1'b0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_inp_addr = '0;
        cmd_wgt_addr = '0;
        cmd_acc_addr = '0;
        cmd_zero     = 1'b0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;
        inp_q        = '0;
        wgt_q        = '0;
        acc_q        = '0;
        for (int i = 0; i < 16; i++) begin
            inp_mem[i] = '0;
            wgt_mem[i] = '0;
        end
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 16; j++) shadow[i][j] = 32'd0;
        end
        set_inp(1, 8'd1);
        set_wgt(2, 8'd1);

        test_reset();
        for (int i = 0; i < 64; i++) preload_acc(6'(i), 32'd0);
        test_single();
        test_overwrite();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_cap();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gemm_acc_rmw.md
# gemm_acc_rmw

Read-modify-write sequencer that closes the accumulation loop around the combinational `gemm_op` core.
- Per accepted command it reads one input tensor, one weight tensor and one accumulator row from three single-port BRAMs (`bram_sp`, 1-cycle read latency).
- It presents the accumulator row, or zero, to `gemm_op` as `a_tensor` and captures `o_tensor`.
- It writes the result back to the same accumulator address.
- It is the writer side of the accumulator BRAM, which the GEMM datapath otherwise only reads.

## Interface
Parameters:
- INP_ADDR_W, 4, input BRAM address width
- WGT_ADDR_W, 4, weight BRAM address width
- ACC_ADDR_W, 6, accumulator BRAM address width
- ACC_WIDTH, 32, bits per accumulator lane
- INP_DEPTH, 16, lanes per row; AT_WIDTH = ACC_WIDTH*INP_DEPTH

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state changes on the rising edge
  - rst_n  in  1  asynchronous active-low reset
- Command interface:
  - cmd_valid  in  1  command present
  - cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
  - cmd_inp_addr  in  INP_ADDR_W  input row address
  - cmd_wgt_addr  in  WGT_ADDR_W  weight block address
  - cmd_acc_addr  in  ACC_ADDR_W  accumulator row address, read then written
  - cmd_zero  in  1  1: use 0 instead of the stored accumulator (overwrite mode)
- Input and weight BRAM ports:
  - inp_en  out  1  input BRAM enable (read only)
  - inp_addr  out  INP_ADDR_W  input BRAM address
  - wgt_en  out  1  weight BRAM enable (read only)
  - wgt_addr  out  WGT_ADDR_W  weight BRAM address
- Accumulator BRAM port:
  - acc_en  out  1  accumulator BRAM enable
  - acc_we  out  1  accumulator BRAM write enable
  - acc_addr  out  ACC_ADDR_W  accumulator BRAM address
  - acc_din  out  AT_WIDTH  write data
  - acc_dout  in  AT_WIDTH  read data, valid the cycle after a read
- `gemm_op` connection:
  - a_tensor  out  AT_WIDTH  to `gemm_op.a_tensor`
  - o_tensor  in  AT_WIDTH  from `gemm_op.o_tensor` (combinational)
- Status:
  - done  out  1  one-cycle pulse per completed write-back
  - busy  out  1  state != IDLE

## Operation
FSM states: IDLE, RD, CAP, WR.
- IDLE: cmd_ready=1. On handshake, latch the three addresses and cmd_zero, then go to RD.
- RD: inp_en=wgt_en=acc_en=1, acc_we=0, addresses driven from the latched values. Go to CAP.
- CAP: BRAM outputs are valid and `gemm_op` evaluates combinationally. Register wb_q <= o_tensor. Go to WR.
- WR: acc_en=1, acc_we=1, acc_addr=latched address, acc_din=wb_q, done=1, cmd_ready=1.
  - On handshake: latch the new command and go to RD.
  - Otherwise: go to IDLE.
- Datapath and control rules:
  - a_tensor = zero_q ? 0 : acc_dout, combinational at all times. It is only meaningful in CAP.
  - Lane arithmetic is done inside `gemm_op` and wraps modulo 2^ACC_WIDTH. This block adds no saturation and performs no width change.
  - cmd_ready is 0 in RD and CAP. Command fields are ignored unless a handshake occurs.
  - inp_en, wgt_en and acc_en are 0 in any state not listed above. acc_we is 1 only in WR.
  - No forwarding logic: a read of the same address issued the cycle after WR observes the written data, because the write completes at the WR clock edge.

## Timing
- Reset values while rst_n=0: state=IDLE, busy=0, done=0, all enables 0, latched addresses 0, zero_q=0, wb_q=0, cmd_ready=1.
- Command accepted at edge T:
  - RD in cycle T+1.
  - CAP in T+2.
  - WR and done in T+3.
- Throughput:
  - Back-to-back commands (handshake in WR) are issued one every 3 cycles.
  - An isolated command is issued one every 4 cycles (the extra cycle is IDLE).
- Reset asserted mid-operation: the FSM returns to IDLE immediately and the pending write is dropped. acc_we must fall with rst_n, with no partial write cycle after release.
- cmd_valid held high with cmd_ready=0: no effect, and the command is not latched twice.
- cmd_zero=1: the acc read is still issued in RD (uniform timing) and its data is ignored.
- Address wrap is not applicable: addresses come from the command, not from counters.

## Test plan
- Single accumulate: acc[3] = all lanes 10, inp row and weight block all 1 (INP_DEPTH=16), cmd_acc_addr=3, cmd_zero=0. Expect acc[3] = all lanes 26, done high exactly at T+3, and busy high for T+1..T+3.
- Overwrite mode: same data with cmd_zero=1. Expect acc[3] = all lanes 16, independent of the prior contents.
- Back-to-back same address: two commands to acc[5] (initially 0) with inp/wgt all 1, second cmd_valid held high. Expect the handshake in WR, done pulses 3 cycles apart, and final acc[5] = 32 per lane (no lost update).
- Back-pressure: cmd_valid held high during RD/CAP with changing addresses. Expect only the values present at the handshake edge to be used, and exactly one write per handshake.
- Wrap: acc lane = 0xFFFFFFF0, product sum 16. Expect the written lane = 0x00000000.
- Reset in CAP: deassert rst_n for 1 cycle during CAP. Expect no acc_we pulse, acc contents unchanged, and cmd_ready=1 after release.
